// File: rtl/branch_predictor.sv
// branch_predictor
//   Dynamic branch predictor for the fetch stage. A direct-mapped BTB with
//   per-entry 2-bit saturating counters predicts the next fetch PC in the
//   same cycle. Resolved conditional branches from EX train the table, and
//   the block counts resolved and mispredicted branches.
//
// Ports
//   clk            clock, all state updates on posedge
//   rst            synchronous active-high reset
//   rdy            global ready; low freezes table and statistics
//   query_pc       fetch PC from IF
//   predicted_pc   predicted next fetch PC (combinational)
//   pred_taken     1 = BTB hit with counter in a taken state
//   upd_valid      resolved conditional branch from EX this cycle
//   upd_pc         PC of the resolved branch
//   upd_taken      resolved direction
//   upd_target     resolved taken target
//   upd_mispredict EX reported a mispredict (ignored unless upd_valid)
//   stat_branches  resolved-branch count (wraps)
//   stat_mispred   mispredicted-branch count (wraps)
module branch_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [ADDR_WIDTH-1:0] query_pc,
  output logic [ADDR_WIDTH-1:0] predicted_pc,
  output logic                  pred_taken,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  upd_mispredict,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispred
);

  localparam int ENTRIES   = 1 << INDEX_BITS;
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_BITS - 2;

  logic                  valid_q  [ENTRIES];
  logic [TAG_WIDTH-1:0]  tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] q_idx;
  logic [TAG_WIDTH-1:0]  q_tag;
  logic [INDEX_BITS-1:0] u_idx;
  logic [TAG_WIDTH-1:0]  u_tag;
  logic                  q_hit;
  logic                  u_hit;

  // Instruction PCs are word aligned; the low two bits carry no information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{query_pc[1:0], upd_pc[1:0]};

  assign q_idx = query_pc[INDEX_BITS+1:2];
  assign q_tag = query_pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign u_idx = upd_pc[INDEX_BITS+1:2];
  assign u_tag = upd_pc[ADDR_WIDTH-1:INDEX_BITS+2];

  assign q_hit = valid_q[q_idx] && (tag_q[q_idx] == q_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Lookup sees only registered state: an update in the same cycle is not
  // bypassed, even to the same index.
  assign pred_taken   = !rst && q_hit && ctr_q[q_idx][1];
  assign predicted_pc = pred_taken ? target_q[q_idx]
                                   : query_pc + ADDR_WIDTH'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (rdy && upd_valid) begin
      stat_branches <= stat_branches + STAT_WIDTH'(1);
      stat_mispred  <= stat_mispred + STAT_WIDTH'(upd_mispredict);
      if (u_hit) begin
        if (upd_taken) begin
          if (ctr_q[u_idx] != 2'b11) ctr_q[u_idx] <= ctr_q[u_idx] + 2'b01;
          target_q[u_idx] <= upd_target;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        // Only taken branches earn a BTB slot; a not-taken miss leaves the
        // current occupant (possibly an alias) alone.
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        ctr_q[u_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] query_pc;
  logic [31:0] predicted_pc;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .query_pc(query_pc), .predicted_pc(predicted_pc), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  // Reference model: one record per table slot holding the full PC of the
  // branch that owns it; a lookup hits when the PCs agree above bit 7.
  typedef struct {
    bit          v;
    logic [31:0] owner;
    logic [31:0] tgt;
    int          ctr;
  } ent_t;

  typedef struct {
    logic [31:0] q;
    bit          taken;
    logic [31:0] npc;
    logic [31:0] br;
    logic [31:0] mp;
  } exp_t;

  ent_t        tbl[64];
  logic [31:0] m_br, m_mp;
  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      tbl[i].v = 0; tbl[i].owner = 0; tbl[i].tgt = 0; tbl[i].ctr = 1;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  // Drive one cycle of stimulus, record what the DUT must show during this
  // cycle, then advance the model past the next rising edge.
  task automatic step(input bit r, input bit rd, input logic [31:0] q,
                      input bit uv, input logic [31:0] up, input bit ut,
                      input logic [31:0] utg, input bit um);
    exp_t e;
    int   s;
    bit   hit;
    rst = r; rdy = rd; query_pc = q; upd_valid = uv; upd_pc = up;
    upd_taken = ut; upd_target = utg; upd_mispredict = um;
    s   = slot(q);
    hit = tbl[s].v && ((tbl[s].owner >> 8) == (q >> 8));
    e.q     = q;
    e.taken = !r && hit && (tbl[s].ctr >= 2);
    e.npc   = e.taken ? tbl[s].tgt : q + 32'd4;
    e.br    = m_br;
    e.mp    = m_mp;
    exp_q.push_back(e);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (rd && uv) begin
      m_br = m_br + 1;
      if (um) m_mp = m_mp + 1;
      s = slot(up);
      if (tbl[s].v && ((tbl[s].owner >> 8) == (up >> 8))) begin
        if (ut) begin
          if (tbl[s].ctr < 3) tbl[s].ctr++;
          tbl[s].tgt = utg;
        end else if (tbl[s].ctr > 0) begin
          tbl[s].ctr--;
        end
      end else if (ut) begin
        tbl[s].v = 1; tbl[s].owner = up; tbl[s].tgt = utg; tbl[s].ctr = 2;
      end
    end
    #1;
  endtask

  task automatic query(input logic [31:0] q);
    step(0, 1, q, 0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic train(input logic [31:0] pc, input bit t, input logic [31:0] tg,
                       input bit um);
    step(0, 1, 32'h0000_8000, 1, pc, t, tg, um);
  endtask

  // Monitor: outputs are combinational, so the DUT presents a response every
  // cycle; check it on the falling edge against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (pred_taken !== e.taken) begin
        fails++;
        $display("FAIL pred_taken q=%h got %b want %b", e.q, pred_taken, e.taken);
      end
      tests++;
      if (predicted_pc !== e.npc) begin
        fails++;
        $display("FAIL predicted_pc q=%h got %h want %h", e.q, predicted_pc, e.npc);
      end
      tests++;
      if (stat_branches !== e.br) begin
        fails++;
        $display("FAIL stat_branches got %0d want %0d", stat_branches, e.br);
      end
      tests++;
      if (stat_mispred !== e.mp) begin
        fails++;
        $display("FAIL stat_mispred got %0d want %0d", stat_mispred, e.mp);
      end
    end
  end

  initial begin
    int budget;
    logic [31:0] pc, tg;
    bit r, rd, uv, ut, um;

    model_reset();
    rst = 1; rdy = 1; query_pc = 0; upd_valid = 0; upd_pc = 0;
    upd_taken = 0; upd_target = 0; upd_mispredict = 0;
    @(posedge clk); #1;

    // reset and cold lookup
    step(1, 1, 32'h1000, 0, 0, 0, 0, 0);
    query(32'h1000);

    // first taken allocates; visible next cycle
    step(0, 1, 32'h1000, 1, 32'h1000, 1, 32'h0F00, 1);
    query(32'h1000);

    // saturation and hysteresis
    for (int i = 0; i < 3; i++) train(32'h1000, 1, 32'h0F00, 0);
    train(32'h1000, 0, 0, 1);
    train(32'h1000, 0, 0, 1);
    query(32'h1000);
    train(32'h1000, 0, 0, 1);
    query(32'h1000);

    // aliasing at index 0
    train(32'h1000, 1, 32'h0F00, 0);
    train(32'h1100, 1, 32'h0A00, 0);
    query(32'h1000);
    query(32'h1100);
    train(32'h1200, 0, 0, 0);
    query(32'h1100);
    query(32'h1200);

    // same-cycle update and query
    step(0, 1, 32'h2000, 1, 32'h2000, 1, 32'h3000, 1);
    query(32'h2000);

    // rdy low freezes table and stats
    step(0, 0, 32'h2040, 1, 32'h2040, 1, 32'h4000, 1);
    query(32'h2040);
    step(0, 0, 32'h2000, 1, 32'h2000, 0, 0, 1);
    query(32'h2000);

    // stats from a clean start: 10 updates, 4 mispredicts
    step(1, 1, 32'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      step(0, 1, 32'h0, 1, 32'h3000 + 32'(i * 4), (i % 2) == 0, 32'h5000, (i % 3) == 0);
    step(0, 1, 32'h0, 0, 0, 0, 0, 1);
    query(32'h3000);

    // reset mid-sequence discards history
    train(32'h3004, 1, 32'h6000, 1);
    step(1, 1, 32'h3000, 1, 32'h3000, 1, 32'h7000, 1);
    query(32'h3000);
    query(32'h0F00);

    // randomized traffic over a few aliasing pages and indices
    for (int n = 0; n < 600; n++) begin
      pc = 32'h1000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 5)) << 2);
      tg = {$urandom_range(0, 32'hFFFF), 2'b00};
      r  = ($urandom_range(0, 99) < 2);
      rd = ($urandom_range(0, 9) != 0);
      uv = ($urandom_range(0, 3) != 0);
      ut = $urandom_range(0, 1) == 1;
      um = $urandom_range(0, 1) == 1;
      step(r, rd, ($urandom_range(0, 1) == 1) ? pc
                  : (32'h1000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 5)) << 2)),
           uv, pc, ut, tg, um);
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain left %0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
